match_controller: RTL

//  Round/match sequencer for the two-player tank game.
//  - Owns the match FSM: attract, countdown, play, round end, match end.
//  - Watches both players' lives and decides round and match winners.
//  - Picks the next arena from the LFSR output and pulses new_level to the players and the map ROM.
//  - Drives a freeze output that gates player movement and shooting.
//  - Sits between keyboard/random and player/map/color_mapper; timing comes from VGA vs.

---
 rtl/game_pkg.sv | 37 +++
 rtl/frame_tick_sync.sv | 32 +++
 rtl/match_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the tank game match sequencer.
// The optional pause feature is enabled by defining MATCH_PAUSE_EN.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        ROUND_END = 3'd3,
        MATCH_END = 3'd4,
        PAUSED    = 3'd5
    } match_state_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    localparam int COUNTDOWN_FRAMES_DEF = 180;
    localparam int ROUND_END_FRAMES_DEF = 120;
    localparam int ROUNDS_TO_WIN_DEF    = 3;
    localparam int NUM_LEVELS_DEF       = 8;

    // Out-of-range candidates fall back to arena 0; a repeat steps forward.
    function automatic logic [9:0] next_level(
        input logic [9:0] cur,
        input logic [9:0] rnd,
        input int         n
    );
        logic [9:0] cand;
        cand = (int'(rnd) >= n) ? 10'd0 : rnd;
        if (cand == cur)
            return (int'(cur) == n - 1) ? 10'd0 : cur + 10'd1;
        return cand;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Used for vs (frame tick), start and pause.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic i_level,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    // Chain resets to 1 so a level held high through reset is not an edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_prev  <= 1'b1;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_level;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer for the two-player tank game.
// Define MATCH_PAUSE_EN to add the PAUSED state driven by the pause key.
module match_controller
    import game_pkg::*;
#(
    parameter int COUNTDOWN_FRAMES = COUNTDOWN_FRAMES_DEF,
    parameter int ROUND_END_FRAMES = ROUND_END_FRAMES_DEF,
    parameter int ROUNDS_TO_WIN    = ROUNDS_TO_WIN_DEF,
    parameter int NUM_LEVELS       = NUM_LEVELS_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       vs,
    input  logic       start,
    input  logic [9:0] p1_lives,
    input  logic [9:0] p2_lives,
    input  logic [9:0] random_number,
    input  logic       pause,
    output logic       new_level,
    output logic [9:0] level_sel,
    output logic [1:0] winner,
    output logic       freeze,
    output logic [7:0] countdown,
    output logic [2:0] p1_score,
    output logic [2:0] p2_score,
    output logic [2:0] match_state
);

    localparam logic [7:0] L_CD  = 8'(COUNTDOWN_FRAMES);
    localparam logic [7:0] L_RE  = 8'(ROUND_END_FRAMES);
    localparam logic [2:0] L_RTW = 3'(ROUNDS_TO_WIN);

    logic w_tick;
    logic w_start_p;
    logic w_pause_p;

    frame_tick_sync u_vs_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_level (vs),
        .o_pulse (w_tick)
    );

    frame_tick_sync u_start_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_level (start),
        .o_pulse (w_start_p)
    );

    frame_tick_sync u_pause_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_level (pause),
        .o_pulse (w_pause_p)
    );

`ifndef MATCH_PAUSE_EN
    logic w_pause_unused;
    assign w_pause_unused = w_pause_p;
`endif

    match_state_t r_state, w_state_nx;
    logic [7:0]   r_cnt, w_cnt_nx;
    logic [2:0]   r_p1, w_p1_nx;
    logic [2:0]   r_p2, w_p2_nx;
    logic [1:0]   r_win, w_win_nx;
    logic [9:0]   r_lvl, w_lvl_nx;
    logic         r_nl, w_nl_nx;
    logic         w_enter_cd;
    logic         w_p1_dead;
    logic         w_p2_dead;
    logic         w_match_won;

    assign w_p1_dead   = (p1_lives == 10'd0);
    assign w_p2_dead   = (p2_lives == 10'd0);
    assign w_match_won = (r_p1 == L_RTW) || (r_p2 == L_RTW);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_p1    <= 3'd0;
            r_p2    <= 3'd0;
            r_win   <= W_NONE;
            r_lvl   <= 10'd0;
            r_nl    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_p1    <= w_p1_nx;
            r_p2    <= w_p2_nx;
            r_win   <= w_win_nx;
            r_lvl   <= w_lvl_nx;
            r_nl    <= w_nl_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_p1_nx    = r_p1;
        w_p2_nx    = r_p2;
        w_win_nx   = r_win;
        w_lvl_nx   = r_lvl;
        w_nl_nx    = 1'b0;
        w_enter_cd = 1'b0;
        unique case (r_state)
            IDLE, MATCH_END: begin
                if (w_start_p) begin
                    w_enter_cd = 1'b1;
                    w_p1_nx    = 3'd0;
                    w_p2_nx    = 3'd0;
                    w_win_nx   = W_NONE;
                end
            end
            COUNTDOWN: begin
                if (w_tick) begin
                    if (r_cnt == 8'd1)
                        w_state_nx = PLAY;
                    else
                        w_cnt_nx = r_cnt - 8'd1;
                end
            end
            PLAY: begin
                if (w_tick && (w_p1_dead || w_p2_dead)) begin
                    w_state_nx = ROUND_END;
                    w_cnt_nx   = L_RE;
                    if (w_p1_dead && w_p2_dead) begin
                        w_win_nx = W_DRAW;
                    end else if (w_p1_dead) begin
                        w_win_nx = W_P2;
                        w_p2_nx  = (r_p2 == 3'd7) ? r_p2 : r_p2 + 3'd1;
                    end else begin
                        w_win_nx = W_P1;
                        w_p1_nx  = (r_p1 == 3'd7) ? r_p1 : r_p1 + 3'd1;
                    end
                end
`ifdef MATCH_PAUSE_EN
                else if (w_pause_p) begin
                    w_state_nx = PAUSED;
                end
`endif
            end
            ROUND_END: begin
                if (w_tick) begin
                    if (r_cnt != 8'd1)
                        w_cnt_nx = r_cnt - 8'd1;
                    else if (w_match_won)
                        w_state_nx = MATCH_END;
                    else
                        w_enter_cd = 1'b1;
                end
            end
`ifdef MATCH_PAUSE_EN
            PAUSED: begin
                if (w_pause_p)
                    w_state_nx = PLAY;
            end
`endif
            default: w_state_nx = IDLE;
        endcase
        // Every COUNTDOWN entry picks a new arena and pulses new_level once.
        if (w_enter_cd) begin
            w_state_nx = COUNTDOWN;
            w_cnt_nx   = L_CD;
            w_nl_nx    = 1'b1;
            w_lvl_nx   = next_level(r_lvl, random_number, NUM_LEVELS);
        end
    end

    assign new_level   = r_nl;
    assign level_sel   = r_lvl;
    assign winner      = r_win;
    assign freeze      = (r_state != PLAY);
    assign countdown   = (r_state == COUNTDOWN) ? r_cnt : 8'd0;
    assign p1_score    = r_p1;
    assign p2_score    = r_p2;
    assign match_state = r_state;

endmodule
